// File: rtl/tt_um_iterative_unrotator.sv
// Iterative inverse of the barrel-shifter tile: restores a rotated word one bit per clock.
// Uses the Tiny Tapeout pin frame and a start/busy/done handshake.
module tt_um_iterative_unrotator #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned AMT_W = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   data_r, data_n;
  logic [AMT_W-1:0]   cnt, cnt_n;
  logic               dir_r, dir_n;
  logic               start_q;

  logic [WIDTH-1:0]   in_data;
  logic [AMT_W-1:0]   in_amt;
  logic               in_dir;
  logic               start;
  logic               start_rise;
  logic               busy;
  logic               done;
  logic               _unused;

  assign in_data    = ui_in[WIDTH-1:0];
  assign in_amt     = ui_in[WIDTH+AMT_W-1:WIDTH];
  assign in_dir     = ui_in[WIDTH+AMT_W];
  assign start      = ui_in[7];
  assign start_rise = start & ~start_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (ena) begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r  <= '0;
      cnt     <= '0;
      dir_r   <= 1'b0;
      start_q <= 1'b0;
    end else if (ena) begin
      data_r  <= data_n;
      cnt     <= cnt_n;
      dir_r   <= dir_n;
      start_q <= start;
    end
  end

  always_comb begin
    state_n = state;
    data_n  = data_r;
    cnt_n   = cnt;
    dir_n   = dir_r;
    case (state)
      IDLE, DONE: begin
        if (start_rise) begin
          data_n  = in_data;
          cnt_n   = in_amt;
          dir_n   = in_dir;
          state_n = (in_amt == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // A word that was rotated left is undone by rotating right, and vice versa.
        data_n = dir_r ? {data_r[0], data_r[WIDTH-1:1]}
                       : {data_r[WIDTH-2:0], data_r[WIDTH-1]};
        cnt_n  = cnt - AMT_W'(1);
        if (cnt == AMT_W'(1)) begin
          state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy    = (state == RUN);
  assign done    = (state == DONE);
  assign uo_out  = {cnt, done, busy, data_r};
  assign uio_out = '0;
  assign uio_oe  = '0;
  assign _unused = &{1'b0, uio_in};

endmodule

// File: tb/tb_tt_um_iterative_unrotator.sv
// Bench for tt_um_iterative_unrotator: scoreboard of expected restored words,
// handshake/latency checks, reset abort, start-level hold and random ena stalls.
module tb_tt_um_iterative_unrotator;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int unsigned n_cmp;
  int unsigned n_err;
  logic [3:0]  exp_q[$];

  tt_um_iterative_unrotator #(
    .WIDTH(4),
    .AMT_W(2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] rotl(input logic [3:0] x, input logic [1:0] a);
    logic [7:0] w;
    w = {x, x} << a;
    return w[7:4];
  endfunction

  function automatic logic [3:0] rotr(input logic [3:0] x, input logic [1:0] a);
    logic [7:0] w;
    w = {x, x} >> a;
    return w[3:0];
  endfunction

  // One operation: drive a start pulse, then follow busy/remaining until done.
  task automatic run_op(input logic [3:0] data, input logic [1:0] amt, input logic dir,
                        input logic [3:0] exp_res, input bit rnd_ena, input bit glitch);
    int unsigned cyc;
    int unsigned en_cyc;
    logic [3:0]  e;
    cyc    = 0;
    en_cyc = 0;
    @(negedge clk);
    ena   = 1'b1;
    ui_in = {1'b1, dir, amt, data};
    exp_q.push_back(exp_res);
    @(negedge clk);
    ui_in = 8'h00;
    while (!uo_out[5] && cyc < 200) begin
      check("busy_run", {7'd0, uo_out[4]}, 8'd1);
      check("remaining", {6'd0, uo_out[7:6]}, 8'(amt) - 8'(en_cyc));
      ui_in = (glitch && cyc == 1) ? 8'hD5 : 8'h00;
      if (rnd_ena) ena = 1'($urandom_range(0, 1));
      @(negedge clk);
      cyc++;
      if (ena) en_cyc++;
    end
    ena   = 1'b1;
    ui_in = 8'h00;
    check("done", {7'd0, uo_out[5]}, 8'd1);
    check("latency", 8'(en_cyc), 8'(amt));
    check("busy_at_done", {7'd0, uo_out[4]}, 8'd0);
    check("remaining_done", {6'd0, uo_out[7:6]}, 8'd0);
    e = exp_q.pop_front();
    check("result", {4'd0, uo_out[3:0]}, {4'd0, e});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned busy_cnt;
    n_cmp  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'hFF;
    uio_in = 8'hA5;
    #12;
    check("reset_uo_out", uo_out, 8'h00);
    check("uio_out", uio_out, 8'h00);
    check("uio_oe", uio_oe, 8'h00);
    @(negedge clk);
    ui_in = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_uo_out", uo_out, 8'h00);

    run_op(4'b0111, 2'd1, 1'b1, 4'b1011, 1'b0, 1'b0);
    run_op(4'b1001, 2'd0, 1'b0, 4'b1001, 1'b0, 1'b0);
    run_op(4'b1110, 2'd3, 1'b0, 4'b0111, 1'b0, 1'b0);

    // start held high: exactly one operation, busy for exactly amt cycles
    busy_cnt = 0;
    @(negedge clk);
    ui_in = {1'b1, 1'b0, 2'd2, 4'b0110};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (uo_out[4]) busy_cnt++;
    end
    check("hold_busy_cycles", 8'(busy_cnt), 8'd2);
    check("hold_done", {7'd0, uo_out[5]}, 8'd1);
    check("hold_result", {4'd0, uo_out[3:0]}, 8'h09);
    ui_in = 8'h00;
    @(negedge clk);

    run_op(4'b1110, 2'd3, 1'b0, 4'b0111, 1'b0, 1'b1);

    // asynchronous reset in the middle of RUN
    @(negedge clk);
    ui_in = {1'b1, 1'b0, 2'd3, 4'b1110};
    @(negedge clk);
    ui_in = 8'h00;
    @(negedge clk);
    check("mid_run_busy", {7'd0, uo_out[4]}, 8'd1);
    #2 rst_n = 1'b0;
    #1 check("abort_uo_out", uo_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(4'b1110, 2'd3, 1'b0, 4'b0111, 1'b0, 1'b0);

    for (int o = 0; o < 16; o++) begin
      for (int a = 0; a < 4; a++) begin
        for (int d = 0; d < 2; d++) begin
          logic [3:0] w;
          w = (d == 1) ? rotl(4'(o), 2'(a)) : rotr(4'(o), 2'(a));
          run_op(w, 2'(a), 1'(d), 4'(o), 1'b0, 1'b0);
        end
      end
    end

    for (int k = 0; k < 24; k++) begin
      logic [3:0] o;
      logic [1:0] a;
      logic       d;
      o = 4'($urandom_range(0, 15));
      a = 2'($urandom_range(0, 3));
      d = 1'($urandom_range(0, 1));
      run_op(d ? rotl(o, a) : rotr(o, a), a, d, o, 1'b1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
